// File: rtl/trng_postproc_pkg.sv
// trng_pkg: shared widths and parameter defaults for the TRNG post-processor.
package trng_pkg;
    localparam int TRNG_BYTE_W        = 8;
    localparam int TRNG_DECIM_DEF     = 4;
    localparam int TRNG_RCT_LIMIT_DEF = 32;
    localparam int TRNG_OVF_W_DEF     = 8;
    typedef logic [TRNG_BYTE_W-1:0] trng_byte_t;
endpackage

// File: rtl/trng_postproc_if.sv
// trng_postproc_if: valid/ready byte stream from the post-processor to its consumer.
interface trng_postproc_if;
    import trng_pkg::*;
    trng_byte_t rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    modport master (output rnd_data, rnd_valid, input rnd_ready);
    modport slave  (input rnd_data, rnd_valid, output rnd_ready);
endinterface

// File: rtl/trng_postproc_rct.sv
// trng_rct: repetition-count health test; sticky fail once a run of identical bits reaches RCT_LIMIT.
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT = TRNG_RCT_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_strobe,
    input  logic i_bit,
    output logic o_fail
);
    localparam int CW = $clog2(RCT_LIMIT + 1);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_last;
    // A zero count marks the first strobe after reset or clear.
    always_comb
        w_cnt_nxt = (r_cnt == '0 || i_bit != r_last) ? CW'(1) :
                    (r_cnt == CW'(RCT_LIMIT))         ? r_cnt  : r_cnt + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
            o_fail <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_last <= 1'b0;
            o_fail <= 1'b0;
        end else if (i_strobe) begin
            r_cnt  <= w_cnt_nxt;
            r_last <= i_bit;
            if (w_cnt_nxt == CW'(RCT_LIMIT))
                o_fail <= 1'b1;
        end
    end
endmodule

// File: rtl/trng_postproc.sv
// trng_postproc: decimate raw STR words, XOR-fold to bits, health-test, von Neumann de-bias
// and pack into bytes on a one-entry valid/ready output register.
module trng_postproc
    import trng_pkg::*;
#(
    parameter int DECIM     = TRNG_DECIM_DEF,
    parameter int RCT_LIMIT = TRNG_RCT_LIMIT_DEF,
    parameter int OVF_W     = TRNG_OVF_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  trng_byte_t             raw_byte,
    trng_postproc_if.master        rnd,
    output logic                   hlth_fail,
    input  logic                   hlth_clr,
    output logic [OVF_W-1:0]       ovf_cnt
);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int BW = $clog2(TRNG_BYTE_W);
    logic [DW-1:0] r_dcnt;
    logic          r_pair;
    logic          r_first;
    trng_byte_t    r_shreg;
    logic [BW-1:0] r_bcnt;
    logic          w_strobe;
    logic          w_raw;
    logic          w_vn;
    logic          w_done;
    trng_byte_t    w_byte;

    assign w_strobe = en && (r_dcnt == DW'(DECIM - 1));
    assign w_raw    = ^raw_byte;
    assign w_vn     = w_strobe && !hlth_fail && r_pair && (r_first != w_raw);
    assign w_done   = w_vn && (r_bcnt == BW'(TRNG_BYTE_W - 1));
    // A 10 pair emits 1 and a 01 pair emits 0, i.e. always the first bit of the pair.
    assign w_byte   = {r_shreg[TRNG_BYTE_W-2:0], r_first};

    trng_rct #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (hlth_clr),
        .i_strobe (w_strobe),
        .i_bit    (w_raw),
        .o_fail   (hlth_fail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt        <= '0;
            r_pair        <= 1'b0;
            r_first       <= 1'b0;
            r_shreg       <= '0;
            r_bcnt        <= '0;
            rnd.rnd_data  <= '0;
            rnd.rnd_valid <= 1'b0;
            ovf_cnt       <= '0;
        end else if (hlth_clr) begin
            r_dcnt        <= '0;
            r_pair        <= 1'b0;
            r_shreg       <= '0;
            r_bcnt        <= '0;
            rnd.rnd_valid <= 1'b0;
        end else begin
            if (en)
                r_dcnt <= w_strobe ? '0 : r_dcnt + 1'b1;
            if (hlth_fail) begin
                r_pair  <= 1'b0;
                r_shreg <= '0;
                r_bcnt  <= '0;
            end else if (w_strobe) begin
                r_pair <= !r_pair;
                if (!r_pair)
                    r_first <= w_raw;
                if (w_vn) begin
                    r_shreg <= w_byte;
                    r_bcnt  <= r_bcnt + 1'b1;
                end
            end
            // A byte completing while the held one is still unaccepted is dropped and counted.
            if (hlth_fail)
                rnd.rnd_valid <= 1'b0;
            else if (w_done && (!rnd.rnd_valid || rnd.rnd_ready)) begin
                rnd.rnd_data  <= w_byte;
                rnd.rnd_valid <= 1'b1;
            end else if (w_done)
                ovf_cnt <= (&ovf_cnt) ? ovf_cnt : ovf_cnt + 1'b1;
            else if (rnd.rnd_valid && rnd.rnd_ready)
                rnd.rnd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: directed vectors for trng_postproc with DECIM=1 (u_a) and DECIM=4 (u_b).
module tb_trng_postproc;
    import trng_pkg::*;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       hlth_clr;
    logic       ready;
    logic [7:0] raw_byte;
    logic       fail_a;
    logic       fail_b;
    logic [7:0] ovf_a;
    logic [7:0] ovf_b;
    int         n_cmp = 0;
    int         n_err = 0;

    trng_postproc_if ifa ();
    trng_postproc_if ifb ();
    assign ifa.rnd_ready = ready;
    assign ifb.rnd_ready = ready;

    always #5 clk = ~clk;

    trng_postproc #(.DECIM(1), .RCT_LIMIT(32), .OVF_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .raw_byte(raw_byte), .rnd(ifa.master),
        .hlth_fail(fail_a), .hlth_clr(hlth_clr), .ovf_cnt(ovf_a)
    );
    trng_postproc #(.DECIM(4), .RCT_LIMIT(32), .OVF_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .raw_byte(raw_byte), .rnd(ifb.master),
        .hlth_fail(fail_b), .hlth_clr(hlth_clr), .ovf_cnt(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a random word with the requested parity for one clock, then sample after the edge.
    task automatic cyc(input logic p);
        logic [7:0] r;
        r = 8'($urandom);
        r[0] = r[0] ^ (^r) ^ p;
        raw_byte = r;
        @(posedge clk);
        #1;
    endtask

    task automatic vn_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            cyc(b[i]);
            cyc(!b[i]);
        end
    endtask

    task automatic clr();
        hlth_clr = 1'b1;
        cyc(1'b0);
        hlth_clr = 1'b0;
    endtask

    initial begin
        logic [0:3]  p0110;
        logic [0:23] s2;
        p0110 = 4'b0110;
        s2    = 24'b00_10_11_10_00_10_11_10_10_10_10_10;
        rst = 1'b1; en = 1'b1; hlth_clr = 1'b0; ready = 1'b1; raw_byte = 8'h00;
        #12;
        chk("rst_valid", ifa.rnd_valid, 0);
        chk("rst_data", ifa.rnd_data, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_ovf", ovf_a, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 1: 0110 x4 -> 8'h55, valid for exactly one cycle
        clr();
        for (int i = 0; i < 15; i++) cyc(p0110[i % 4]);
        chk("t1_valid_early", ifa.rnd_valid, 0);
        cyc(p0110[3]);
        chk("t1_valid", ifa.rnd_valid, 1);
        chk("t1_data", ifa.rnd_data, 8'h55);
        cyc(1'b0);
        chk("t1_valid_drop", ifa.rnd_valid, 0);

        // 2: 00/11 pairs add nothing
        clr();
        for (int i = 0; i < 24; i++) cyc(s2[i]);
        chk("t2_valid", ifa.rnd_valid, 1);
        chk("t2_data", ifa.rnd_data, 8'hFF);
        chk("t2_ovf", ovf_a, 0);

        // 3: overflow with ready low
        clr();
        ready = 1'b0;
        vn_byte(8'hFF);
        chk("t3_valid1", ifa.rnd_valid, 1);
        vn_byte(8'h00);
        chk("t3_data_held", ifa.rnd_data, 8'hFF);
        chk("t3_valid_held", ifa.rnd_valid, 1);
        chk("t3_ovf", ovf_a, 1);
        ready = 1'b1;
        cyc(1'b0);
        chk("t3_valid_after_hs", ifa.rnd_valid, 0);

        // 4: repetition-count trip and clear
        clr();
        repeat (31) cyc(1'b1);
        chk("t4_fail_31", fail_a, 0);
        cyc(1'b1);
        chk("t4_fail_32", fail_a, 1);
        chk("t4_valid_32", ifa.rnd_valid, 0);
        vn_byte(8'hFF);
        chk("t4_valid_blocked", ifa.rnd_valid, 0);
        chk("t4_fail_sticky", fail_a, 1);
        clr();
        chk("t4_fail_clr", fail_a, 0);
        vn_byte(8'hFF);
        chk("t4_valid_resume", ifa.rnd_valid, 1);
        chk("t4_data_resume", ifa.rnd_data, 8'hFF);
        chk("t4_ovf_kept", ovf_a, 1);

        // 5: DECIM=4, non-strobe parities ignored, en=0 freezes the phase
        clr();
        for (int s = 0; s < 16; s++) begin
            cyc(1'b0); cyc(1'b1); cyc(1'b0);
            cyc(s % 2 == 0);
            if (s == 7) begin
                en = 1'b0;
                for (int k = 0; k < 10; k++) cyc(k[0]);
                chk("t5_valid_en0", ifb.rnd_valid, 0);
                en = 1'b1;
            end
        end
        chk("t5_valid", ifb.rnd_valid, 1);
        chk("t5_data", ifb.rnd_data, 8'hFF);

        // 6: asynchronous reset mid-byte with a byte held
        clr();
        ready = 1'b0;
        vn_byte(8'hFF);
        chk("t6_valid_pre", ifa.rnd_valid, 1);
        repeat (5) begin cyc(1'b1); cyc(1'b0); end
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_valid", ifa.rnd_valid, 0);
        chk("t6_rst_data", ifa.rnd_data, 0);
        chk("t6_rst_fail", fail_a, 0);
        chk("t6_rst_ovf", ovf_a, 0);
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 16; i++) cyc(p0110[i % 4]);
        chk("t6_valid", ifa.rnd_valid, 1);
        chk("t6_data", ifa.rnd_data, 8'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
